kernel_window_gen: RTL and testbench

Parametrised 3x3 neighbourhood generator for the CCD edge-filter pipeline. It consumes a raster pixel stream with arbitrary valid gaps and stores two lines internally. For every input pixel it emits one complete 3x3 window centred on that pixel, including border pixels, using selectable zero or replicate padding. It replaces fixed-size window logic upstream of the coefficient multiply/accumulate stage and adds a ready handshake plus an end-of-frame flush.

---
 rtl/kernel_window_gen.sv | 211 +++++++++++++++++++++
 tb/tb_kernel_window_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_window_gen.sv
// kernel_window_gen
//   Turns a raster pixel stream into one 3x3 neighbourhood per input pixel.
//   The window is centred on that pixel and padded at the frame borders with
//   zeros or replicated edge pixels. Two line stores hold the previous two rows.
//   Windows trail the input by one row. The last row is emitted by a flush
//   phase after the final pixel of the frame has been accepted.
//
// Ports
//   clk             rising-edge clock
//   aclr            asynchronous active-low reset
//   data_valid_in   input pixel qualifier
//   data            input pixel (raster order, x fastest)
//   data_ready      block can accept a pixel this cycle
//   edge_mode       0 = zero padding, 1 = replicate; latched with pixel (0,0)
//   rowR_C          window, rowR_C = pixel(cy+R-2, cx+C-2)
//   data_valid_out  one-cycle pulse per window
//   out_eol         window centre is the last column
//   out_last        final window of the frame
module kernel_window_gen #(
  parameter int DW      = 30,
  parameter int LINE_W  = 12,
  parameter int FRAME_H = 16
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          data_valid_in,
  input  logic [DW-1:0] data,
  output logic          data_ready,
  input  logic          edge_mode,
  output logic [DW-1:0] row1_1,
  output logic [DW-1:0] row1_2,
  output logic [DW-1:0] row1_3,
  output logic [DW-1:0] row2_1,
  output logic [DW-1:0] row2_2,
  output logic [DW-1:0] row2_3,
  output logic [DW-1:0] row3_1,
  output logic [DW-1:0] row3_2,
  output logic [DW-1:0] row3_3,
  output logic          data_valid_out,
  output logic          out_eol,
  output logic          out_last
);

  localparam int XW = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

  typedef enum logic [1:0] {FILL, RUN, EDGE, FLUSH} state_t;
  // One window column: [0] = top row, [2] = bottom row.
  typedef logic [2:0][DW-1:0] col_t;
  // Whole window indexed [column][row].
  typedef logic [2:0][2:0][DW-1:0] win_t;

  state_t        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          mode_q;
  logic          ready_q;
  logic          vld_q, eol_q, last_q;
  win_t          win_q;

  // Storage without reset: stale contents are always masked by padding.
  logic [DW-1:0] line_a_q [LINE_W];  // row y-1
  logic [DW-1:0] line_b_q [LINE_W];  // row y-2
  col_t          c0_q, c1_q;         // columns x-2 and x-1 of rows y-2..y

  logic accept;
  assign accept = data_valid_in & ready_q;

  // Replace an out-of-range top/bottom row with zero or the middle row.
  function automatic col_t pad_rows(input col_t c, input logic top,
                                    input logic bot, input logic rep);
    col_t r;
    r = c;
    if (top) r[0] = rep ? c[1] : '0;
    if (bot) r[2] = rep ? c[1] : '0;
    return r;
  endfunction

  col_t          new_col;
  win_t          run_win, edge_win, flush_win;
  logic          top_pad;
  logic [XW-1:0] xl, xr;

  always_comb begin
    // RUN/EDGE windows are centred on row y-1; row y-2 is missing for y=1.
    top_pad = (y_q == YW'(1));
    new_col = {data, line_a_q[x_q], line_b_q[x_q]};

    // Window for centre (y-1, x-1) from the two held columns plus the new one.
    run_win[1] = pad_rows(c1_q, top_pad, 1'b0, mode_q);
    run_win[2] = pad_rows(new_col, top_pad, 1'b0, mode_q);
    if (x_q == XW'(1)) run_win[0] = mode_q ? run_win[1] : '0;
    else               run_win[0] = pad_rows(c0_q, top_pad, 1'b0, mode_q);

    // Right-edge window: held columns are LINE_W-2 and LINE_W-1.
    edge_win[0] = pad_rows(c0_q, top_pad, 1'b0, mode_q);
    edge_win[1] = pad_rows(c1_q, top_pad, 1'b0, mode_q);
    edge_win[2] = mode_q ? edge_win[1] : '0;

    // Flush windows read the line stores directly, column x reused as centre.
    // Clamped indices give replicate padding; zero mode masks afterwards.
    xl = (x_q == '0)     ? x_q : x_q - XW'(1);
    xr = (x_q == X_LAST) ? x_q : x_q + XW'(1);
    flush_win[0] = pad_rows({{DW{1'b0}}, line_a_q[xl],  line_b_q[xl]},  1'b0, 1'b1, mode_q);
    flush_win[1] = pad_rows({{DW{1'b0}}, line_a_q[x_q], line_b_q[x_q]}, 1'b0, 1'b1, mode_q);
    flush_win[2] = pad_rows({{DW{1'b0}}, line_a_q[xr],  line_b_q[xr]},  1'b0, 1'b1, mode_q);
    if (!mode_q && x_q == '0)     flush_win[0] = '0;
    if (!mode_q && x_q == X_LAST) flush_win[2] = '0;
  end

  always_ff @(posedge clk) begin
    if (accept && (state_q == FILL || state_q == RUN)) begin
      line_b_q[x_q] <= line_a_q[x_q];
      line_a_q[x_q] <= data;
      c0_q          <= c1_q;
      c1_q          <= new_col;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= FILL;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      vld_q  <= 1'b0;
      eol_q  <= 1'b0;
      last_q <= 1'b0;
      case (state_q)
        FILL: begin
          ready_q <= 1'b1;  // also raises ready on the first edge after reset
          if (accept) begin
            if (x_q == '0) mode_q <= edge_mode;
            if (x_q == X_LAST) begin
              x_q     <= '0;
              y_q     <= YW'(1);
              state_q <= RUN;
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (x_q != '0) begin
              vld_q <= 1'b1;
              win_q <= run_win;
            end
            if (x_q == X_LAST) begin
              x_q     <= '0;
              ready_q <= 1'b0;
              state_q <= EDGE;
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        EDGE: begin
          vld_q <= 1'b1;
          eol_q <= 1'b1;
          win_q <= edge_win;
          if (y_q == Y_LAST) begin
            state_q <= FLUSH;  // x_q is already 0 for the first flush column
          end else begin
            y_q     <= y_q + YW'(1);
            ready_q <= 1'b1;
            state_q <= RUN;
          end
        end
        FLUSH: begin
          vld_q <= 1'b1;
          win_q <= flush_win;
          if (x_q == X_LAST) begin
            eol_q   <= 1'b1;
            last_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            ready_q <= 1'b1;
            state_q <= FILL;
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign data_ready     = ready_q;
  assign data_valid_out = vld_q;
  assign out_eol        = eol_q;
  assign out_last       = last_q;
  assign row1_1 = win_q[0][0];
  assign row1_2 = win_q[1][0];
  assign row1_3 = win_q[2][0];
  assign row2_1 = win_q[0][1];
  assign row2_2 = win_q[1][1];
  assign row2_3 = win_q[2][1];
  assign row3_1 = win_q[0][2];
  assign row3_2 = win_q[1][2];
  assign row3_3 = win_q[2][2];

endmodule

// File: tb/tb_kernel_window_gen.sv
module tb_kernel_window_gen;
  localparam int DW = 8, LW = 4, FH = 3, NW = LW * FH, NB = 6;

  logic clk = 1'b0, aclr = 1'b0, dvi = 1'b0, em = 1'b0;
  logic [DW-1:0] din = '0;
  logic dready, dvo, eol, last;
  logic [DW-1:0] r11, r12, r13, r21, r22, r23, r31, r32, r33;

  kernel_window_gen #(.DW(DW), .LINE_W(LW), .FRAME_H(FH)) dut (
    .clk(clk), .aclr(aclr), .data_valid_in(dvi), .data(din),
    .data_ready(dready), .edge_mode(em),
    .row1_1(r11), .row1_2(r12), .row1_3(r13),
    .row2_1(r21), .row2_2(r22), .row2_3(r23),
    .row3_1(r31), .row3_2(r32), .row3_3(r33),
    .data_valid_out(dvo), .out_eol(eol), .out_last(last));

  always #5 clk = ~clk;

  typedef logic [8:0][DW-1:0] win_t;  // [R*3+C] for rowR+1_C+1
  typedef struct { win_t w; logic eol; logic last; } obs_t;
  typedef struct { int k; int v[9]; bit eol; bit last; } vec_t;

  obs_t          obs[$];
  logic [DW-1:0] frm [NB][FH][LW];
  int            checks = 0, failures = 0;

  // Capture every emitted window.
  always @(negedge clk) begin
    obs_t o;
    if (aclr && dvo) begin
      o.w = {r33, r32, r31, r23, r22, r21, r13, r12, r11};
      o.eol = eol;
      o.last = last;
      obs.push_back(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input bit ok, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pixel lookup with padding, straight from the border rules.
  function automatic logic [DW-1:0] pxl(input int b, input bit mode, input int r, input int c);
    if (mode) begin
      if (r < 0) r = 0;
      if (r > FH - 1) r = FH - 1;
      if (c < 0) c = 0;
      if (c > LW - 1) c = LW - 1;
      return frm[b][r][c];
    end
    if (r < 0 || r >= FH || c < 0 || c >= LW) return '0;
    return frm[b][r][c];
  endfunction

  function automatic obs_t ref_win(input int b, input bit mode, input int cy, input int cx);
    obs_t o;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        o.w[r*3+c] = pxl(b, mode, cy + r - 1, cx + c - 1);
    o.eol = (cx == LW - 1);
    o.last = (cy == FH - 1) && (cx == LW - 1);
    return o;
  endfunction

  function automatic logic [73:0] pk(input obs_t o);
    return {o.eol, o.last, o.w};
  endfunction

  task automatic compare_frame(input int b, input bit mode, input int base);
    chk("window_count_min", obs.size() >= base + NW, obs.size(), base + NW);
    for (int k = 0; k < NW; k++) begin
      obs_t e;
      e = ref_win(b, mode, k / LW, k % LW);
      if (base + k < obs.size())
        chk("window_vs_model", pk(obs[base+k]) == pk(e), pk(obs[base+k]), pk(e));
    end
  endtask

  task automatic send_frame(input int b, input bit mode, input int gap, input bit rnd,
                            input bit hold, input int npix);
    for (int i = 0; i < npix; i++) begin
      int y, x, g, n, ex;
      y = i / LW;
      x = i % LW;
      g = rnd ? int'($urandom_range(gap, 0)) : gap;
      if (g > 0) begin
        dvi = 1'b0;
        repeat (g) @(negedge clk);
      end
      dvi = 1'b1;
      din = frm[b][y][x];
      em  = (i == 0) ? mode : ~mode;  // only pixel (0,0) may set the mode
      n = 0;
      while (!dready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("ready_wait", n < 50, n, 50);
      if (n >= 50) begin
        dvi = 1'b0;
        return;
      end
      @(negedge clk);  // accepted on the rising edge just passed
      dvi = 1'b0;
      chk("dvo_after_accept", dvo === (y >= 1 && x >= 1), dvo, (y >= 1 && x >= 1));
      if (x == LW - 1 && y >= 1) begin
        if (hold) begin
          // Present the next pixel (or junk after the frame) while ready is low.
          dvi = 1'b1;
          din = (i + 1 < npix) ? frm[b][(i+1)/LW][(i+1)%LW] : 8'hEE;
          em  = ~mode;
        end
        n = 0;
        while (!dready && n < 20) begin
          n++;
          @(negedge clk);
        end
        ex = (y == FH - 1) ? LW + 1 : 1;
        chk("ready_low_cycles", n == ex, n, ex);
        dvi = 1'b0;
      end
    end
    dvi = 1'b0;
  endtask

  initial begin
    vec_t tbl[5];
    int   base, idx;
    obs_t e;
    bit   m[4];

    tbl[0].k = 0;  tbl[0].v = '{0,0,0, 0,1,2, 0,11,12};     tbl[0].eol = 0; tbl[0].last = 0;
    tbl[1].k = 3;  tbl[1].v = '{0,0,0, 3,4,0, 13,14,0};     tbl[1].eol = 1; tbl[1].last = 0;
    tbl[2].k = 11; tbl[2].v = '{13,14,0, 23,24,0, 0,0,0};   tbl[2].eol = 1; tbl[2].last = 1;
    tbl[3].k = 12; tbl[3].v = '{1,1,2, 1,1,2, 11,11,12};    tbl[3].eol = 0; tbl[3].last = 0;
    tbl[4].k = 23; tbl[4].v = '{13,14,14, 23,24,24, 23,24,24}; tbl[4].eol = 1; tbl[4].last = 1;

    for (int b = 0; b < NB; b++)
      for (int y = 0; y < FH; y++)
        for (int x = 0; x < LW; x++)
          frm[b][y][x] = (b < 2) ? DW'(10 * y + x + 1) : DW'($urandom);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_outputs", {dvo, eol, last, dready, r11, r12, r13, r21, r22, r23, r31, r32, r33} == '0,
        {dvo, eol, last, dready, r11, r12, r13, r21, r22, r23, r31, r32, r33}, 0);
    aclr = 1'b1;
    chk("ready_low_before_edge", dready == 1'b0, dready, 0);
    @(negedge clk);
    chk("ready_after_reset", dready == 1'b1, dready, 1);

    // Frame A zero mode, frame B replicate mode, back to back, continuous.
    base = obs.size();
    send_frame(0, 1'b0, 0, 1'b0, 1'b0, NW);
    send_frame(1, 1'b1, 0, 1'b0, 1'b0, NW);
    @(negedge clk);
    compare_frame(0, 1'b0, base);
    compare_frame(1, 1'b1, base + NW);
    chk("count_ab", obs.size() == base + 2 * NW, obs.size(), base + 2 * NW);
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < 9; j++) e.w[j] = DW'(tbl[t].v[j]);
      e.eol = tbl[t].eol;
      e.last = tbl[t].last;
      idx = base + tbl[t].k;
      chk("table_idx", idx < obs.size(), obs.size(), idx + 1);
      if (idx < obs.size()) chk("table_window", pk(obs[idx]) == pk(e), pk(obs[idx]), pk(e));
    end

    // Sparse: two idle cycles between pixels, valid held during ready-low.
    base = obs.size();
    send_frame(0, 1'b0, 2, 1'b0, 1'b1, NW);
    @(negedge clk);
    compare_frame(0, 1'b0, base);
    chk("count_sparse", obs.size() == base + NW, obs.size(), base + NW);

    // Reset mid-frame after accepting (1,2).
    send_frame(0, 1'b1, 0, 1'b0, 1'b0, LW + 3);
    aclr = 1'b0;
    #1;
    chk("midreset_outputs", {dvo, eol, last, dready, r11, r12, r13, r21, r22, r23, r31, r32, r33} == '0,
        {dvo, eol, last, dready, r11, r12, r13, r21, r22, r23, r31, r32, r33}, 0);
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", dready == 1'b1, dready, 1);
    base = obs.size();
    send_frame(0, 1'b0, 0, 1'b0, 1'b0, NW);
    @(negedge clk);
    compare_frame(0, 1'b0, base);
    chk("count_after_reset", obs.size() == base + NW, obs.size(), base + NW);
    for (int j = 0; j < 9; j++) e.w[j] = DW'(tbl[0].v[j]);
    e.eol = 1'b0;
    e.last = 1'b0;
    if (base < obs.size()) chk("first_after_reset", pk(obs[base]) == pk(e), pk(obs[base]), pk(e));

    // Random pixels, modes, gaps and holds, frames back to back.
    base = obs.size();
    for (int f = 0; f < 4; f++) begin
      m[f] = 1'($urandom);
      send_frame(2 + f, m[f], 3, 1'b1, 1'($urandom), NW);
    end
    @(negedge clk);
    for (int f = 0; f < 4; f++) compare_frame(2 + f, m[f], base + f * NW);
    chk("count_random", obs.size() == base + 4 * NW, obs.size(), base + 4 * NW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
